score_keeper: RTL

- Game-score state block directly upstream of the 7-segment score overlay; drives its 4-bit `score` input (0-9).
- Counts collection events from the game logic.
- Commits at most one point per video frame on the frame tick, so the digit never changes mid-frame.
- Runs a small IDLE/PLAY/WIN state machine.

---
 rtl/score_keeper_if.sv | 36 +++
 rtl/score_keeper.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/score_keeper_if.sv
// -----------------------------------------------------------------------------
// score_keeper_if
// Bundles the game-side event inputs and the score/status outputs of
// score_keeper.
//   master : game logic / overlay side (drives i_*, observes o_*)
//   slave  : score_keeper itself (observes i_*, drives o_*)
// Signals:
//   i_start         level, acted on as a rising edge
//   i_collect       level from collision logic, each rising edge = one event
//   i_frame_tick    one-cycle pulse at start of vertical blank
//   o_score         committed score 0..MAX_SCORE, feeds the overlay digit
//   o_playing       high in PLAY
//   o_win           high in WIN
//   o_pending_full  pending-event counter at saturation
//   o_score_visible overlay enable, ANDed downstream with the digit pixel
// -----------------------------------------------------------------------------
interface score_keeper_if;
   logic       i_start;
   logic       i_collect;
   logic       i_frame_tick;
   logic [3:0] o_score;
   logic       o_playing;
   logic       o_win;
   logic       o_pending_full;
   logic       o_score_visible;

   modport master (
      output i_start, i_collect, i_frame_tick,
      input  o_score, o_playing, o_win, o_pending_full, o_score_visible
   );

   modport slave (
      input  i_start, i_collect, i_frame_tick,
      output o_score, o_playing, o_win, o_pending_full, o_score_visible
   );
endinterface

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
// Game-score state block feeding the 7-segment score overlay. Collection
// events are accumulated in a saturating pending counter and committed to the
// displayed score at most one point per video frame, on the frame tick, so
// the digit never changes mid-frame. A small IDLE/PLAY/WIN machine gates it.
//
// Ports:
//   i_clk    system/pixel clock
//   i_rst_n  asynchronous active-low reset
//   bus      score_keeper_if.slave (start/collect/frame_tick in,
//            score/playing/win/pending_full/score_visible out)
//
// Parameters:
//   MAX_SCORE     winning score, 1..9 (one displayed digit)
//   PEND_W        pending-event counter width, saturates at 2^PEND_W-1
//   BLINK_FRAMES  frames per blink half-period in WIN (SCORE_BLINK_EN only)
//
// Optional feature macro: SCORE_BLINK_EN
//   defined   : the digit blinks in WIN, toggling every BLINK_FRAMES ticks
//   undefined : o_score_visible is tied high
// -----------------------------------------------------------------------------
module score_keeper #(
   parameter int MAX_SCORE    = 9,
   parameter int PEND_W       = 3,
   parameter int BLINK_FRAMES = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   score_keeper_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_WIN  = 2'd2;

   localparam logic [3:0]        SCORE_MAX = 4'(MAX_SCORE);
   localparam logic [PEND_W-1:0] PEND_SAT  = '1;

   logic [1:0]        r_state;
   logic [3:0]        r_score;
   logic [PEND_W-1:0] r_pending;
   logic              r_start_d;
   logic              r_collect_d;

   logic [1:0]        w_state_nx;
   logic [3:0]        w_score_nx;
   logic [PEND_W-1:0] w_pending_nx;
   logic              w_start_re;
   logic              w_collect_re;
   logic              w_commit;
   logic              w_accept;

   // Edge registers start at 0 out of reset.
   assign w_start_re   = bus.i_start   & ~r_start_d;
   assign w_collect_re = bus.i_collect & ~r_collect_d;

   always_comb begin
      w_state_nx   = r_state;
      w_score_nx   = r_score;
      w_pending_nx = r_pending;
      w_commit     = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         ST_PLAY: begin
            w_commit = bus.i_frame_tick && (r_pending != '0);
            // A commit frees one slot in the same cycle, so a coincident
            // event is still accepted even when the counter is saturated.
            w_accept = w_collect_re && ((r_pending != PEND_SAT) || w_commit);
            if (w_commit) begin
               w_score_nx = r_score + 4'd1;
            end
            if (w_commit && !w_accept) begin
               w_pending_nx = r_pending - 1'b1;
            end else if (!w_commit && w_accept) begin
               w_pending_nx = r_pending + 1'b1;
            end
            if (w_commit && (w_score_nx == SCORE_MAX)) begin
               w_state_nx   = ST_WIN;
               w_pending_nx = '0;
            end
         end
         ST_IDLE, ST_WIN: begin
            // Collect is ignored here; a coincident collect edge is dropped.
            if (w_start_re) begin
               w_state_nx   = ST_PLAY;
               w_score_nx   = 4'd0;
               w_pending_nx = '0;
            end
         end
         default: begin
            w_state_nx   = ST_IDLE;
            w_score_nx   = 4'd0;
            w_pending_nx = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_score     <= 4'd0;
         r_pending   <= '0;
         r_start_d   <= 1'b0;
         r_collect_d <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_score     <= w_score_nx;
         r_pending   <= w_pending_nx;
         r_start_d   <= bus.i_start;
         r_collect_d <= bus.i_collect;
      end
   end

   assign bus.o_score        = r_score;
   assign bus.o_playing      = (r_state == ST_PLAY);
   assign bus.o_win          = (r_state == ST_WIN);
   assign bus.o_pending_full = (r_pending == PEND_SAT);

`ifdef SCORE_BLINK_EN
   localparam int                CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0] r_blink_cnt;
   logic             r_visible;

   // Counter only runs while staying in WIN; entering or leaving WIN
   // restarts it with the digit shown.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_blink_cnt <= '0;
         r_visible   <= 1'b1;
      end else if ((r_state != ST_WIN) || (w_state_nx != ST_WIN)) begin
         r_blink_cnt <= '0;
         r_visible   <= 1'b1;
      end else if (bus.i_frame_tick) begin
         if (r_blink_cnt == CNT_LAST) begin
            r_blink_cnt <= '0;
            r_visible   <= ~r_visible;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end

   assign bus.o_score_visible = r_visible;
`else
   assign bus.o_score_visible = 1'b1;
`endif

endmodule
